siphash_msg_ctrl: RTL

Message-level sequencer for the single-cycle-round SipHash core. It accepts a key, a byte length and a stream of 64-bit little-endian message words. It drives the core's initialize / compress / finalize strobes with the correct SipHash length/padding block. It returns a 64-bit tag, so upstream logic never handles core handshakes or padding.

---
 rtl/siphash_msg_ctrl_pkg.sv | 48 ++++
 rtl/siphash_msg_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/siphash_msg_ctrl_pkg.sv
// Shared SipHash definitions: init constants, default round counts, controller
// state encoding and the length/padding block helper.
package siphash_msg_ctrl_pkg;

  localparam logic [63:0] SIP_INIT_V0 = 64'h736f6d6570736575;
  localparam logic [63:0] SIP_INIT_V1 = 64'h646f72616e646f6d;
  localparam logic [63:0] SIP_INIT_V2 = 64'h6c7967656e657261;
  localparam logic [63:0] SIP_INIT_V3 = 64'h7465646279746573;

  localparam logic [3:0] DEF_C_ROUNDS = 4'd2;
  localparam logic [3:0] DEF_D_ROUNDS = 4'd4;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_INIT  = 4'd1;
  localparam logic [3:0] ST_GET   = 4'd2;
  localparam logic [3:0] ST_COMP  = 4'd3;
  localparam logic [3:0] ST_CWAIT = 4'd4;
  localparam logic [3:0] ST_FIN   = 4'd5;
  localparam logic [3:0] ST_FWAIT = 4'd6;
  localparam logic [3:0] ST_DONE  = 4'd7;
  localparam logic [3:0] ST_DRAIN = 4'd8;

  typedef enum logic [3:0] {
    S_IDLE  = ST_IDLE,
    S_INIT  = ST_INIT,
    S_GET   = ST_GET,
    S_COMP  = ST_COMP,
    S_CWAIT = ST_CWAIT,
    S_FIN   = ST_FIN,
    S_FWAIT = ST_FWAIT,
    S_DONE  = ST_DONE,
    S_DRAIN = ST_DRAIN
  } state_t;

  // Length byte in the top lane, OR'd with the low rem bytes of the last word.
  // rem = 0 yields the bare length block.
  function automatic logic [63:0] final_block(input logic [63:0] word,
                                              input logic [2:0]  rem,
                                              input logic [7:0]  len_byte);
    logic [63:0] mask;
    mask = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(rem)) mask[8*i +: 8] = 8'hff;
    end
    return {len_byte, 56'h0} | (word & mask);
  endfunction

endpackage

// File: rtl/siphash_msg_ctrl.sv
// Message-level sequencer for the single-cycle-round SipHash core: feeds
// message words and the length/padding block, then returns the 64-bit tag.
//
// state | meaning
// IDLE  | waiting for start
// INIT  | core_initalize strobe
// GET   | pick next core input (data word, final block) or go finalize
// COMP  | core_compress strobe
// CWAIT | wait for core_ready (first cycle ignored)
// FIN   | core_finalize strobe
// FWAIT | wait for core_ready && core_word_valid (first cycle ignored)
// DONE  | tag_valid pulse
// DRAIN | aborted; wait for the core to go idle, no strobes
module siphash_msg_ctrl
  import siphash_msg_ctrl_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [127:0]     key,
  input  logic [LEN_W-1:0] msg_len,
  input  logic [3:0]       c_rounds,
  input  logic [3:0]       d_rounds,
  input  logic             abort,
  input  logic [63:0]      s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [63:0]      tag,
  output logic             tag_valid,
  output logic             busy,
  output logic             core_initalize,
  output logic             core_compress,
  output logic             core_finalize,
  output logic             core_long,
  output logic [127:0]     core_key,
  output logic [63:0]      core_mi,
  output logic [3:0]       core_compression_rounds,
  output logic [3:0]       core_final_rounds,
  input  logic             core_ready,
  input  logic             core_word_valid,
  input  logic [127:0]     core_word
);

  localparam int WC_W = LEN_W - 2;

  state_t          state;
  state_t          state_next;
  logic [WC_W-1:0] words_left;
  logic [2:0]      rem_q;
  logic [7:0]      len_byte;
  logic            fin_sent;
  logic            skip;
  logic [63:0]     mi_next;
  logic            take_word;
  logic            fin_set;
  logic            tag_load;

  assign s_ready   = (state == S_GET) && (words_left != '0);
  assign core_long = 1'b0;

  always_comb begin
    state_next = state;
    mi_next    = core_mi;
    take_word  = 1'b0;
    fin_set    = 1'b0;
    tag_load   = 1'b0;
    if (abort && (state != S_IDLE) && (state != S_DRAIN)) begin
      state_next = S_DRAIN;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) state_next = S_INIT;
        end
        S_INIT: state_next = S_GET;
        S_GET: begin
          if (words_left != '0) begin
            if (s_valid) begin
              take_word  = 1'b1;
              state_next = S_COMP;
              if ((words_left == WC_W'(1)) && (rem_q != 3'd0)) begin
                mi_next = final_block(s_data, rem_q, len_byte);
                fin_set = 1'b1;
              end else begin
                mi_next = s_data;
              end
            end
          end else if (!fin_sent) begin
            mi_next    = final_block(64'h0, 3'd0, len_byte);
            fin_set    = 1'b1;
            state_next = S_COMP;
          end else begin
            state_next = S_FIN;
          end
        end
        S_COMP: state_next = S_CWAIT;
        // skip covers the cycle where the core has not yet dropped ready
        S_CWAIT: begin
          if (!skip && core_ready) state_next = S_GET;
        end
        S_FIN: state_next = S_FWAIT;
        S_FWAIT: begin
          if (!skip && core_ready && core_word_valid) begin
            tag_load   = 1'b1;
            state_next = S_DONE;
          end
        end
        S_DONE: state_next = S_IDLE;
        S_DRAIN: begin
          if (!skip && core_ready) state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                   <= S_IDLE;
      words_left              <= '0;
      rem_q                   <= '0;
      len_byte                <= '0;
      fin_sent                <= 1'b0;
      skip                    <= 1'b0;
      busy                    <= 1'b0;
      tag_valid               <= 1'b0;
      tag                     <= '0;
      core_initalize          <= 1'b0;
      core_compress           <= 1'b0;
      core_finalize           <= 1'b0;
      core_mi                 <= '0;
      core_key                <= '0;
      core_compression_rounds <= DEF_C_ROUNDS;
      core_final_rounds       <= DEF_D_ROUNDS;
    end else begin
      state          <= state_next;
      skip           <= (state == S_COMP) || (state == S_FIN);
      busy           <= (state_next != S_IDLE);
      tag_valid      <= (state_next == S_DONE);
      core_initalize <= (state_next == S_INIT);
      core_compress  <= (state_next == S_COMP);
      core_finalize  <= (state_next == S_FIN);
      core_mi        <= mi_next;
      if ((state == S_IDLE) && start) begin
        words_left <= WC_W'(msg_len[LEN_W-1:3]) + WC_W'(msg_len[2:0] != 3'd0);
        rem_q      <= msg_len[2:0];
        len_byte   <= msg_len[7:0];
        fin_sent   <= 1'b0;
        core_key   <= key;
        core_compression_rounds <= (c_rounds == 4'd0) ? DEF_C_ROUNDS : c_rounds;
        core_final_rounds       <= (d_rounds == 4'd0) ? DEF_D_ROUNDS : d_rounds;
      end else begin
        if (take_word) words_left <= words_left - WC_W'(1);
        if (fin_set) fin_sent <= 1'b1;
      end
      if (tag_load) tag <= core_word[127:64] ^ core_word[63:0];
    end
  end

endmodule
